product_bcd_converter: RTL and testbench

PRODUCT_BCD_CONVERTER -- requirements
Module: product_bcd_converter

---
 rtl/product_bcd_converter.sv | 157 +++++++++++++++
 tb/tb_product_bcd_converter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/product_bcd_converter.sv
// Purpose : sequential double-dabble conversion of an 8-bit product to three BCD digits
//           (optional seven-segment decode enabled by defining BCD_SEG_DECODE_EN).
// Latency : 9 clocks from the start-sampling edge to the edge that raises valid.
// Backpr. : none; start is accepted only in IDLE and ignored while busy is high.
module product_bcd_converter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] bin_in,
  output logic       busy,
  output logic       valid,
  output logic [3:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones
`ifdef BCD_SEG_DECODE_EN
  ,
  output logic [6:0] seg_hundreds,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        load;
  logic        shift_en;
  logic        done_en;

  logic [7:0]  shreg_q;
  logic [11:0] scratch_q;
  logic [11:0] scratch_adj;
  logic [3:0]  cnt_q;

  // add-3 correction applied to one BCD digit before it is doubled
  function automatic logic [3:0] adj3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

`ifdef BCD_SEG_DECODE_EN
  // active-low seven-segment pattern, bit6=g .. bit0=a
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction
`endif

  assign scratch_adj = {adj3(scratch_q[11:8]), adj3(scratch_q[7:4]), adj3(scratch_q[3:0])};

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and datapath control
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    done_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        // counter reaching 1 here means this edge performs the eighth shift
        if (cnt_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_en = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // shift register, BCD scratch and bit counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q   <= 8'd0;
      scratch_q <= 12'd0;
      cnt_q     <= 4'd0;
    end else if (load) begin
      shreg_q   <= bin_in;
      scratch_q <= 12'd0;
      cnt_q     <= 4'd8;
    end else if (shift_en) begin
      {scratch_q, shreg_q} <= {scratch_adj[10:0], shreg_q, 1'b0};
      cnt_q                <= cnt_q - 4'd1;
    end
  end

  // registered status and result outputs; digits only move on the valid edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      valid        <= 1'b0;
      bcd_hundreds <= 4'd0;
      bcd_tens     <= 4'd0;
      bcd_ones     <= 4'd0;
    end else begin
      busy  <= (state_d != IDLE);
      valid <= done_en;
      if (done_en) begin
        bcd_hundreds <= scratch_q[11:8];
        bcd_tens     <= scratch_q[7:4];
        bcd_ones     <= scratch_q[3:0];
      end
    end
  end

`ifdef BCD_SEG_DECODE_EN
  // segment outputs follow the digits on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_hundreds <= 7'b1000000;
      seg_tens     <= 7'b1000000;
      seg_ones     <= 7'b1000000;
    end else if (done_en) begin
      seg_hundreds <= seg7(scratch_q[11:8]);
      seg_tens     <= seg7(scratch_q[7:4]);
      seg_ones     <= seg7(scratch_q[3:0]);
    end
  end
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// Purpose : self-checking bench for product_bcd_converter against an arithmetic digit model.
// Latency : expects valid exactly 9 edges after the start-sampling edge.
// Backpr. : drives start only when the block should be idle, plus deliberate ignored re-pulses.
module tb_product_bcd_converter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] bin_in;
  logic       busy;
  logic       valid;
  logic [3:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
`ifdef BCD_SEG_DECODE_EN
  logic [6:0] seg_hundreds;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
`endif

  int n_total;
  int n_pass;
  int exp_h;
  int exp_t;
  int exp_o;

  product_bcd_converter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bin_in       (bin_in),
    .busy         (busy),
    .valid        (valid),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones)
`ifdef BCD_SEG_DECODE_EN
    ,
    .seg_hundreds (seg_hundreds),
    .seg_tens     (seg_tens),
    .seg_ones     (seg_ones)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle before touching inputs or sampling outputs
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

`ifdef BCD_SEG_DECODE_EN
  function automatic int seg_ref(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
    return int'(tbl[d]);
  endfunction
`endif

  task automatic chk_digits(input string tag);
    chk({tag, "_h"}, int'(bcd_hundreds), exp_h);
    chk({tag, "_t"}, int'(bcd_tens), exp_t);
    chk({tag, "_o"}, int'(bcd_ones), exp_o);
`ifdef BCD_SEG_DECODE_EN
    chk({tag, "_seg_h"}, int'(seg_hundreds), seg_ref(exp_h));
    chk({tag, "_seg_t"}, int'(seg_tens), seg_ref(exp_t));
    chk({tag, "_seg_o"}, int'(seg_ones), seg_ref(exp_o));
`endif
  endtask

  // one conversion; optionally re-pulse start (value 17) so it is sampled at edge k+3
  task automatic conv(input int v, input bit glitch);
    int nval;
    nval = 0;
    chk("idle_busy_before_start", int'(busy), 0);
    start  = 1'b1;
    bin_in = 8'(v);
    tick();                                   // edge k
    start  = 1'b0;
    bin_in = 8'($urandom_range(0, 255));      // must not be resampled
    chk("busy_after_k", int'(busy), 1);
    for (int i = 1; i <= 9; i++) begin
      if (glitch && i == 3) begin
        start  = 1'b1;
        bin_in = 8'd17;
      end
      tick();                                 // edge k+i
      if (glitch && i == 3) start = 1'b0;
      if (valid) nval++;
      chk($sformatf("busy_k+%0d", i), int'(busy), (i <= 8) ? 1 : 0);
      chk($sformatf("valid_k+%0d", i), int'(valid), (i == 9) ? 1 : 0);
      if (i < 9) chk_digits($sformatf("hold_k+%0d", i));
    end
    exp_h = v / 100;
    exp_t = (v / 10) % 10;
    exp_o = v % 10;
    chk_digits($sformatf("result_%0d", v));
    if (glitch) begin
      for (int i = 0; i < 12; i++) begin
        tick();
        if (valid) nval++;
        chk("no_second_busy", int'(busy), 0);
      end
      chk("single_valid", nval, 1);
      chk_digits("after_ignored_start");
    end
  endtask

  initial begin
    int v;
    n_total = 0;
    n_pass  = 0;
    exp_h   = 0;
    exp_t   = 0;
    exp_o   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    bin_in  = 8'd0;
    #2;
    tick();
    tick();

    // reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk_digits("rst");

    // first start after reset release is honoured on the next edge
    rst_n = 1'b1;
    conv(225, 1'b0);
    tick();
    chk("valid_one_cycle", int'(valid), 0);
    chk_digits("hold_after_valid");

    // boundary values
    conv(0, 1'b0);
    tick();
    conv(255, 1'b0);
    tick();
    conv(99, 1'b0);
    tick();
    conv(49, 1'b0);
    tick();

    // start re-pulsed while busy is ignored
    conv(144, 1'b1);

    // back-to-back: second start issued in the valid cycle
    conv(36, 1'b0);
    chk("b2b_valid_cycle", int'(valid), 1);
    conv(81, 1'b0);
    tick();

    // reset mid-conversion aborts with no valid pulse
    start  = 1'b1;
    bin_in = 8'd200;
    tick();                                   // edge k
    start  = 1'b0;
    tick();
    tick();
    tick();                                   // edge k+3
    rst_n = 1'b0;
    start = 1'b1;                             // must be ignored during reset
    tick();                                   // edge k+4
    exp_h = 0;
    exp_t = 0;
    exp_o = 0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(valid), 0);
    chk_digits("midrst");
    tick();
    chk("rst_start_ignored_busy", int'(busy), 0);
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("midrst_no_valid", int'(valid), 0);
      chk("midrst_no_busy", int'(busy), 0);
    end
    chk_digits("midrst_hold");

    // randomized values against the arithmetic model, some back-to-back
    for (int n = 0; n < 16; n++) begin
      v = int'($urandom_range(0, 255));
      conv(v, 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
